// File: rtl/spi_flash_arbiter_if.sv
// Purpose : bundles the CPU, loader-stream and SPI-engine signals of spi_flash_arbiter.
// Latency : none; this is wiring only.
// Backpressure: the loader stream uses ld_valid/ld_ready. The SPI side is paced by spi_busy.
// Ports: CPU  cpu_go/cpu_txd in, cpu_rxd/cpu_wait out
//        LD   ld_start/ld_addr/ld_len/ld_ready in, ld_data/ld_valid/ld_busy/ld_done out
//        SPI  spi_rxd/spi_busy in, spi_go/spi_txd/flash_cs_n out
// slave = arbiter view, master = environment view (CPU, loader sink, SPI engine).
interface spi_flash_arbiter_if;
   logic        cpu_go;
   logic [7:0]  cpu_txd;
   logic [7:0]  cpu_rxd;
   logic        cpu_wait;
   logic        ld_start;
   logic [23:0] ld_addr;
   logic [15:0] ld_len;
   logic [7:0]  ld_data;
   logic        ld_valid;
   logic        ld_ready;
   logic        ld_busy;
   logic        ld_done;
   logic        spi_go;
   logic [7:0]  spi_txd;
   logic [7:0]  spi_rxd;
   logic        spi_busy;
   logic        flash_cs_n;

   modport slave (
      input  cpu_go, cpu_txd, ld_start, ld_addr, ld_len, ld_ready, spi_rxd, spi_busy,
      output cpu_rxd, cpu_wait, ld_data, ld_valid, ld_busy, ld_done, spi_go, spi_txd, flash_cs_n
   );

   modport master (
      output cpu_go, cpu_txd, ld_start, ld_addr, ld_len, ld_ready, spi_rxd, spi_busy,
      input  cpu_rxd, cpu_wait, ld_data, ld_valid, ld_busy, ld_done, spi_go, spi_txd, flash_cs_n
   );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Purpose : shares one 8-bit SPI engine between single CPU byte transfers and a bulk flash-read loader.
// Latency : a request is latched and then served from IDLE on the next cycle. spi_go is issued one cycle after a byte state is entered.
// Backpressure: a read byte is held in LD_HOLD, and no spi_go is issued, until ld_ready is seen.
// Ports: clk/rst (synchronous, active-high) plus bus (spi_flash_arbiter_if.slave).
//        CPU requests and loader starts each have a single pending slot.
//        Only the loader drives flash_cs_n low.
module spi_flash_arbiter #(
   parameter logic [7:0]  CMD_READ = 8'h03,
   parameter int unsigned CS_GAP   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   spi_flash_arbiter_if.slave   bus
);

   typedef enum logic [3:0] {
      IDLE, CPU_X, LD_CSGAP, LD_CMD, LD_A2, LD_A1, LD_A0, LD_RD, LD_HOLD, LD_END
   } state_t;

   state_t      state_q, state_d;
   logic        cpu_pend_q, cpu_pend_d;
   logic [7:0]  cpu_byte_q, cpu_byte_d;
   logic        ld_pend_q, ld_pend_d;
   logic [23:0] addr_q, addr_d;
   logic [15:0] len_q, len_d;
   logic [15:0] gap_q, gap_d;
   logic        sent_q, sent_d;
   logic        busy_prev_q, busy_prev_d;
   logic        spi_go_q, spi_go_d;
   logic [7:0]  spi_txd_q, spi_txd_d;
   logic [7:0]  cpu_rxd_q, cpu_rxd_d;
   logic [7:0]  ld_data_q, ld_data_d;
   logic        ld_busy_q, ld_busy_d;
   logic        ld_done_q, ld_done_d;
   logic        cs_n_q, cs_n_d;

   logic        xfer_st;
   logic        spi_done;
   logic        gap_last;
   logic [7:0]  tx_byte;

   // The exchange is finished on the first low spi_busy after a high one.
   // Tracking the falling edge keeps this independent of how long the engine takes.
   assign spi_done = sent_q & busy_prev_q & ~bus.spi_busy;
   assign gap_last = (32'(gap_q) + 32'd1) >= CS_GAP;

   always_comb begin
      tx_byte = 8'hFF;
      case (state_q)
         CPU_X:   tx_byte = spi_txd_q;
         LD_CMD:  tx_byte = CMD_READ;
         LD_A2:   tx_byte = addr_q[23:16];
         LD_A1:   tx_byte = addr_q[15:8];
         LD_A0:   tx_byte = addr_q[7:0];
         default: tx_byte = 8'hFF;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cpu_pend_d  = cpu_pend_q;
      cpu_byte_d  = cpu_byte_q;
      ld_pend_d   = ld_pend_q;
      addr_d      = addr_q;
      len_d       = len_q;
      gap_d       = gap_q;
      sent_d      = sent_q;
      busy_prev_d = bus.spi_busy;
      spi_go_d    = 1'b0;
      spi_txd_d   = spi_txd_q;
      cpu_rxd_d   = cpu_rxd_q;
      ld_data_d   = ld_data_q;
      ld_busy_d   = ld_busy_q;
      ld_done_d   = 1'b0;
      cs_n_d      = cs_n_q;

      xfer_st = state_q inside {CPU_X, LD_CMD, LD_A2, LD_A1, LD_A0, LD_RD};

      // Every byte state issues exactly one exchange, and only when the engine is idle.
      if (xfer_st && !sent_q && !bus.spi_busy) begin
         spi_go_d  = 1'b1;
         spi_txd_d = tx_byte;
         sent_d    = 1'b1;
      end
      if (xfer_st && spi_done) begin
         sent_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            // A pending CPU byte always wins over a pending loader start.
            if (cpu_pend_q) begin
               state_d    = CPU_X;
               cpu_pend_d = 1'b0;
               spi_txd_d  = cpu_byte_q;   // frees the slot for a new request
               sent_d     = 1'b0;
            end else if (ld_pend_q) begin
               state_d   = LD_CSGAP;
               ld_pend_d = 1'b0;
               gap_d     = 16'd0;
            end
         end
         CPU_X: begin
            if (spi_done) begin
               cpu_rxd_d = bus.spi_rxd;
               state_d   = IDLE;
            end
         end
         LD_CSGAP: begin
            if (gap_last) begin
               cs_n_d  = 1'b0;
               sent_d  = 1'b0;
               state_d = LD_CMD;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         LD_CMD: if (spi_done) state_d = LD_A2;
         LD_A2:  if (spi_done) state_d = LD_A1;
         LD_A1:  if (spi_done) state_d = LD_A0;
         LD_A0:  if (spi_done) state_d = LD_RD;
         LD_RD: begin
            if (spi_done) begin
               ld_data_d = bus.spi_rxd;
               state_d   = LD_HOLD;
            end
         end
         LD_HOLD: begin
            if (bus.ld_ready) begin
               // Wrapping decrement: a start count of 0 runs 65536 bytes.
               len_d = len_q - 16'd1;
               if (len_q != 16'd1) begin
                  state_d = LD_RD;
               end else begin
                  cs_n_d    = 1'b1;
                  ld_done_d = 1'b1;
                  ld_busy_d = 1'b0;
                  gap_d     = 16'd0;
                  state_d   = LD_END;
               end
            end
         end
         LD_END: begin
            if (gap_last) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Request capture. A loader start is accepted only when no job is active or queued.
      if (bus.ld_start && !ld_busy_q) begin
         ld_pend_d = 1'b1;
         ld_busy_d = 1'b1;
         addr_d    = bus.ld_addr;
         len_d     = bus.ld_len;
      end
      if (bus.cpu_go && !cpu_pend_d) begin
         cpu_pend_d = 1'b1;
         cpu_byte_d = bus.cpu_txd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cpu_pend_q  <= 1'b0;
         cpu_byte_q  <= 8'h00;
         ld_pend_q   <= 1'b0;
         addr_q      <= 24'h0;
         len_q       <= 16'h0;
         gap_q       <= 16'h0;
         sent_q      <= 1'b0;
         busy_prev_q <= 1'b0;
         spi_go_q    <= 1'b0;
         spi_txd_q   <= 8'h00;
         cpu_rxd_q   <= 8'h00;
         ld_data_q   <= 8'h00;
         ld_busy_q   <= 1'b0;
         ld_done_q   <= 1'b0;
         cs_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cpu_pend_q  <= cpu_pend_d;
         cpu_byte_q  <= cpu_byte_d;
         ld_pend_q   <= ld_pend_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         gap_q       <= gap_d;
         sent_q      <= sent_d;
         busy_prev_q <= busy_prev_d;
         spi_go_q    <= spi_go_d;
         spi_txd_q   <= spi_txd_d;
         cpu_rxd_q   <= cpu_rxd_d;
         ld_data_q   <= ld_data_d;
         ld_busy_q   <= ld_busy_d;
         ld_done_q   <= ld_done_d;
         cs_n_q      <= cs_n_d;
      end
   end

   assign bus.spi_go     = spi_go_q;
   assign bus.spi_txd    = spi_txd_q;
   assign bus.cpu_rxd    = cpu_rxd_q;
   assign bus.cpu_wait   = cpu_pend_q | (state_q == CPU_X);
   assign bus.ld_data    = ld_data_q;
   assign bus.ld_valid   = (state_q == LD_HOLD);
   assign bus.ld_busy    = ld_busy_q;
   assign bus.ld_done    = ld_done_q;
   assign bus.flash_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Purpose : directed self-checking bench for spi_flash_arbiter with a behavioural SPI engine.
// Latency : not applicable.
// Backpressure: the bench stalls ld_ready to exercise LD_HOLD.
// SPI model: spi_busy rises the cycle after spi_go and stays high for 4 cycles.
//            The reply for an FF byte is 8'h10 + n, where n counts FF bytes so far.
//            The reply for any other byte is txd ^ 8'h99.
module tb_spi_flash_arbiter;
   logic clk = 1'b0;
   logic rst;

   spi_flash_arbiter_if bus ();

   spi_flash_arbiter #(.CMD_READ(8'h03), .CS_GAP(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ---------------- SPI engine model ----------------
   logic       m_busy = 1'b0;
   logic [1:0] m_cnt  = 2'd0;
   logic [7:0] m_txd  = 8'h00;
   logic [7:0] m_rxd  = 8'h00;
   logic [7:0] rd_idx = 8'h00;

   always @(posedge clk) begin
      if (!m_busy) begin
         if (bus.spi_go) begin
            m_busy <= 1'b1;
            m_cnt  <= 2'd3;
            m_txd  <= bus.spi_txd;
         end
      end else if (m_cnt == 2'd0) begin
         m_busy <= 1'b0;
         if (m_txd == 8'hFF) begin
            m_rxd  <= 8'h10 + rd_idx;
            rd_idx <= rd_idx + 8'd1;
         end else begin
            m_rxd <= m_txd ^ 8'h99;
         end
      end else begin
         m_cnt <= m_cnt - 2'd1;
      end
   end

   assign bus.spi_busy = m_busy;
   assign bus.spi_rxd  = m_rxd;

   // ---------------- monitors (sampled on the falling edge) ----------------
   logic [7:0] log_txd [256];
   logic       log_cs  [256];
   logic [7:0] hs_log  [256];
   int log_n = 0, hs_n = 0, done_n = 0, done_logn = 0;
   int busy_viol = 0, hold_go = 0, cs_edges = 0, cs_stray = 0;
   logic cs_prev = 1'b1;

   always @(negedge clk) begin
      if (bus.spi_go === 1'b1) begin
         if (log_n < 256) begin
            log_txd[log_n] = bus.spi_txd;
            log_cs[log_n]  = bus.flash_cs_n;
         end
         log_n++;
         if (bus.spi_busy) busy_viol++;
         if (bus.ld_valid) hold_go++;
      end
      if (bus.ld_valid === 1'b1 && bus.ld_ready) begin
         if (hs_n < 256) hs_log[hs_n] = bus.ld_data;
         hs_n++;
      end
      if (bus.ld_done === 1'b1) begin
         done_n++;
         done_logn = log_n;
      end
      if (bus.flash_cs_n === ~cs_prev) cs_edges++;
      cs_prev = bus.flash_cs_n;
      if (bus.flash_cs_n === 1'b0 && bus.ld_busy === 1'b0) cs_stray++;
   end

   // ---------------- checking ----------------
   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // sel: 0 done count, 1 handshake count, 2 spi_go count, 3 cpu_wait low, 4 ld_valid high
   task automatic wait_for(input string tag, input int sel, input int target);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 2000 && !hit; k++) begin
         case (sel)
            0:       hit = (done_n >= target);
            1:       hit = (hs_n >= target);
            2:       hit = (log_n >= target);
            3:       hit = (bus.cpu_wait === 1'b0);
            default: hit = (bus.ld_valid === 1'b1);
         endcase
         if (!hit) step();
      end
      chk({tag, "_reached"}, 32'(hit), 32'd1);
   endtask

   task automatic ld_go(input logic [23:0] a, input logic [15:0] l);
      bus.ld_addr  = a;
      bus.ld_len   = l;
      bus.ld_start = 1'b1;
      step();
      bus.ld_start = 1'b0;
   endtask

   task automatic cpu_pulse(input logic [7:0] d);
      bus.cpu_txd = d;
      bus.cpu_go  = 1'b1;
      step();
      bus.cpu_go  = 1'b0;
   endtask

   int n0, h0, d0, e0, g0;
   logic [7:0] exp_seq [7];
   logic stall_bad;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus.cpu_go = 1'b0;   bus.cpu_txd = 8'h00;
      bus.ld_start = 1'b0; bus.ld_addr = 24'h0; bus.ld_len = 16'h0;
      bus.ld_ready = 1'b1;
      repeat (3) step();

      // Reset values
      chk("rst_cs_n",     32'(bus.flash_cs_n), 32'd1);
      chk("rst_spi_go",   32'(bus.spi_go),     32'd0);
      chk("rst_spi_txd",  32'(bus.spi_txd),    32'h00);
      chk("rst_cpu_rxd",  32'(bus.cpu_rxd),    32'h00);
      chk("rst_cpu_wait", 32'(bus.cpu_wait),   32'd0);
      chk("rst_ld_valid", 32'(bus.ld_valid),   32'd0);
      chk("rst_ld_busy",  32'(bus.ld_busy),    32'd0);
      chk("rst_ld_done",  32'(bus.ld_done),    32'd0);
      chk("rst_ld_data",  32'(bus.ld_data),    32'h00);
      rst = 1'b0;
      step();

      // CPU single byte: A5 out, 3C back, chip select untouched
      n0 = log_n; e0 = cs_edges;
      cpu_pulse(8'hA5);
      chk("cpu_wait_pending", 32'(bus.cpu_wait), 32'd1);
      wait_for("cpu1", 3, 0);
      chk("cpu1_go_count", 32'(log_n - n0), 32'd1);
      chk("cpu1_txd",      32'(log_txd[n0]), 32'hA5);
      chk("cpu1_rxd",      32'(bus.cpu_rxd), 32'h3C);
      chk("cpu1_cs_edges", 32'(cs_edges - e0), 32'd0);
      repeat (4) step();

      // Loader job: addr 012345, 3 bytes, sink always ready
      n0 = log_n; h0 = hs_n; d0 = done_n; e0 = cs_edges;
      exp_seq[0] = 8'h03; exp_seq[1] = 8'h01; exp_seq[2] = 8'h23; exp_seq[3] = 8'h45;
      exp_seq[4] = 8'hFF; exp_seq[5] = 8'hFF; exp_seq[6] = 8'hFF;
      ld_go(24'h012345, 16'd3);
      chk("ld1_busy", 32'(bus.ld_busy), 32'd1);
      wait_for("ld1_done", 0, d0 + 1);
      chk("ld1_go_count", 32'(log_n - n0), 32'd7);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("ld1_txd%0d", i), 32'(log_txd[n0 + i]), 32'(exp_seq[i]));
         chk($sformatf("ld1_cs%0d", i),  32'(log_cs[n0 + i]),  32'd0);
      end
      chk("ld1_hs_count", 32'(hs_n - h0), 32'd3);
      chk("ld1_byte0",    32'(hs_log[h0]),     32'h10);
      chk("ld1_byte1",    32'(hs_log[h0 + 1]), 32'h11);
      chk("ld1_byte2",    32'(hs_log[h0 + 2]), 32'h12);
      chk("ld1_cs_edges", 32'(cs_edges - e0), 32'd2);
      chk("ld1_busy_end", 32'(bus.ld_busy), 32'd0);
      chk("ld1_cs_end",   32'(bus.flash_cs_n), 32'd1);
      repeat (8) step();
      chk("ld1_done_once", 32'(done_n - d0), 32'd1);

      // Back-pressure: stall the second byte for 10 cycles
      h0 = hs_n; d0 = done_n;
      ld_go(24'h000010, 16'd3);
      wait_for("ld2_first_hs", 1, h0 + 1);
      bus.ld_ready = 1'b0;
      wait_for("ld2_second_valid", 4, 0);
      g0 = log_n; stall_bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.ld_data !== 8'h14 || bus.ld_valid !== 1'b1) stall_bad = 1'b1;
      end
      chk("ld2_stall_no_go", 32'(log_n - g0), 32'd0);
      chk("ld2_stall_hold",  32'(stall_bad), 32'd0);
      bus.ld_ready = 1'b1;
      wait_for("ld2_done", 0, d0 + 1);
      chk("ld2_hs_count", 32'(hs_n - h0), 32'd3);
      chk("ld2_byte1",    32'(hs_log[h0 + 1]), 32'h14);
      chk("ld2_byte2",    32'(hs_log[h0 + 2]), 32'h15);
      repeat (8) step();

      // CPU and loader requested in the same cycle: CPU first
      n0 = log_n; h0 = hs_n; d0 = done_n;
      bus.cpu_txd = 8'h5A; bus.cpu_go = 1'b1;
      bus.ld_addr = 24'h0000AA; bus.ld_len = 16'd1; bus.ld_start = 1'b1;
      step();
      bus.cpu_go = 1'b0; bus.ld_start = 1'b0;
      wait_for("both_done", 0, d0 + 1);
      chk("both_go_count", 32'(log_n - n0), 32'd6);
      chk("both_first_cpu", 32'(log_txd[n0]), 32'h5A);
      chk("both_cpu_cs",    32'(log_cs[n0]),  32'd1);
      chk("both_then_cmd",  32'(log_txd[n0 + 1]), 32'h03);
      chk("both_addr0",     32'(log_txd[n0 + 4]), 32'hAA);
      chk("both_cpu_rxd",   32'(bus.cpu_rxd), 32'hC3);
      chk("both_ld_byte",   32'(hs_log[h0]), 32'h16);
      repeat (8) step();

      // Two cpu_go during a job: one exchange, after ld_done
      n0 = log_n; h0 = hs_n; d0 = done_n;
      ld_go(24'h000100, 16'd2);
      wait_for("mid_cmd_sent", 2, n0 + 2);
      cpu_pulse(8'h11);
      chk("mid_cpu_wait", 32'(bus.cpu_wait), 32'd1);
      repeat (2) step();
      cpu_pulse(8'h22);
      wait_for("mid_done", 0, d0 + 1);
      wait_for("mid_cpu", 3, 0);
      chk("mid_go_count",   32'(log_n - n0), 32'd7);
      chk("mid_cpu_txd",    32'(log_txd[n0 + 6]), 32'h11);
      chk("mid_after_done", 32'(done_logn - n0), 32'd6);
      chk("mid_cpu_rxd",    32'(bus.cpu_rxd), 32'h88);
      chk("mid_ld_bytes",   32'({hs_log[h0], hs_log[h0 + 1]}), 32'h1718);
      repeat (8) step();

      // Reset inside LD_RD of a 65536-byte job
      h0 = hs_n;
      ld_go(24'h000000, 16'd0);
      wait_for("rst_job_hs", 1, h0 + 2);
      d0 = done_n;
      rst = 1'b1;
      step();
      chk("rstjob_cs_n",  32'(bus.flash_cs_n), 32'd1);
      chk("rstjob_busy",  32'(bus.ld_busy),    32'd0);
      chk("rstjob_done",  32'(bus.ld_done),    32'd0);
      chk("rstjob_valid", 32'(bus.ld_valid),   32'd0);
      rst = 1'b0;
      repeat (30) step();
      chk("rstjob_no_done", 32'(done_n - d0), 32'd0);
      chk("rstjob_idle_cs", 32'(bus.flash_cs_n), 32'd1);

      // Global protocol properties
      chk("go_while_busy", 32'(busy_viol), 32'd0);
      chk("go_while_hold", 32'(hold_go),   32'd0);
      chk("cs_low_idle",   32'(cs_stray),  32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/spi_flash_arbiter.md
SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

Interface
REQ-001 The block SHALL have parameter CMD_READ, default 8'h03, meaning the flash read opcode sent by the loader.
REQ-002 The block SHALL have parameter CS_GAP, default 2, meaning the number of clk cycles flash_cs_n stays high between loader jobs and after a job.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock (7 MHz); all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port cpu_go, input, 1 bit: one-cycle pulse requesting a single CPU byte transfer.
REQ-006 The block SHALL have port cpu_txd, input, 8 bits: the CPU byte to shift out, sampled when cpu_go is high.
REQ-007 The block SHALL have port cpu_rxd, output, 8 bits: the last byte received for the CPU.
REQ-008 The block SHALL have port cpu_wait, output, 1 bit: high while a CPU request is pending or in flight.
REQ-009 The block SHALL have port ld_start, input, 1 bit: one-cycle pulse starting a bulk flash read.
REQ-010 The block SHALL have port ld_addr, input, 24 bits: the flash start address, sampled when ld_start is high.
REQ-011 The block SHALL have port ld_len, input, 16 bits: the byte count, sampled when ld_start is high; 0 means 65536 bytes.
REQ-012 The block SHALL have port ld_data, output, 8 bits: the streamed read byte.
REQ-013 The block SHALL have port ld_valid, output, 1 bit: ld_data is valid.
REQ-014 The block SHALL have port ld_ready, input, 1 bit: the sink accepts the byte; the transfer happens when ld_valid and ld_ready are both high.
REQ-015 The block SHALL have port ld_busy, output, 1 bit: a loader job is active.
REQ-016 The block SHALL have port ld_done, output, 1 bit: one-cycle pulse when a job completes.
REQ-017 The block SHALL have port spi_go, output, 1 bit: one-cycle pulse starting one 8-bit exchange on the SPI engine.
REQ-018 The block SHALL have port spi_txd, output, 8 bits: the byte to send, valid with spi_go.
REQ-019 The block SHALL have port spi_rxd, input, 8 bits: the received byte, valid when spi_busy falls.
REQ-020 The block SHALL have port spi_busy, input, 1 bit: the engine is shifting; it rises the cycle after spi_go.
REQ-021 The block SHALL have port flash_cs_n, output, 1 bit: flash chip select, loader-owned while ld_busy is high.

Function
REQ-022 The block SHALL implement the states IDLE, CPU_X, LD_CSGAP, LD_CMD, LD_A2, LD_A1, LD_A0, LD_RD, LD_HOLD and LD_END.
REQ-023 In IDLE, a pending CPU request SHALL take priority over a pending loader start; when both arrive in the same cycle, CPU_X runs first and the loader start stays latched.
REQ-024 A cpu_go that arrives while the block is not in IDLE SHALL be latched in a single pending slot, with cpu_wait high; a second cpu_go while the slot is full SHALL be ignored.
REQ-025 A CPU transfer SHALL issue spi_go with spi_txd = cpu_txd, wait for spi_busy to fall, capture spi_rxd into cpu_rxd, drop cpu_wait in the same cycle, and return to IDLE.
REQ-026 CPU transfers SHALL NOT drive flash_cs_n.
REQ-027 A loader job SHALL NOT be preempted; CPU requests arriving during a job SHALL wait until LD_END.
REQ-028 Loader job sequence:
- LD_CSGAP: hold flash_cs_n high for CS_GAP cycles, then drive flash_cs_n low.
- LD_CMD: send CMD_READ.
- LD_A2, LD_A1, LD_A0: send ld_addr[23:16], then [15:8], then [7:0].
- LD_RD: send 8'hFF and capture the received byte.
REQ-029 Each byte SHALL wait for spi_busy to fall before the next spi_go is issued; spi_go SHALL never be asserted while spi_busy is high.
REQ-030 After a byte is captured in LD_RD, the block SHALL enter LD_HOLD with ld_valid high.
REQ-031 ld_data SHALL stay stable until the handshake completes.
REQ-032 No further spi_go SHALL be issued while in LD_HOLD; this is the back-pressure mechanism.
REQ-033 On each handshake the 16-bit remaining count SHALL decrement with wrap, so a start value of 0 yields 65536 bytes.
REQ-034 After a handshake, the block SHALL go to LD_RD if the remaining count is nonzero, otherwise to LD_END.
REQ-035 LD_END SHALL raise flash_cs_n, pulse ld_done for one cycle, drop ld_busy, and enforce CS_GAP cycles before returning to IDLE.
REQ-036 ld_busy SHALL be high from the cycle after ld_start is accepted through LD_END.
REQ-037 An ld_start that arrives while ld_busy is high SHALL be ignored.
REQ-038 ld_valid SHALL be high only in LD_HOLD.

Reset
REQ-039 On rst high at a clock edge, the block SHALL enter IDLE and clear both pending slots.
REQ-040 On reset, outputs SHALL take these values: flash_cs_n = 1, spi_go = 0, spi_txd = 8'h00, cpu_rxd = 8'h00, cpu_wait = 0, ld_valid = 0, ld_busy = 0, ld_done = 0, ld_data = 8'h00.
REQ-041 A reset in the middle of a job SHALL abort the job with no ld_done pulse; an SPI exchange in flight completes unobserved.

Verification
REQ-042 The bench SHALL cover: cpu_go with cpu_txd = 8'hA5 and the SPI model returning 8'h3C -> exactly one spi_go with spi_txd = A5, then cpu_rxd = 3C, cpu_wait low, and flash_cs_n never toggles.
REQ-043 The bench SHALL cover: ld_start with ld_addr = 24'h012345 and ld_len = 3, with ld_ready tied high -> spi_txd sequence 03, 01, 23, 45, FF, FF, FF; three ld_valid handshakes; one ld_done; flash_cs_n low only between the first and last spi_go.
REQ-044 The bench SHALL cover: ld_ready low for 10 cycles on the second byte -> no spi_go during the stall and ld_data held constant.
REQ-045 The bench SHALL cover: cpu_go and ld_start in the same cycle -> the CPU exchange completes first, then the loader job starts.
REQ-046 The bench SHALL cover: cpu_go during a job, then a second cpu_go during the same job -> exactly one CPU exchange, issued after ld_done.
REQ-047 The bench SHALL cover: rst asserted in LD_RD with ld_len = 0 -> the next cycle shows flash_cs_n = 1, ld_busy = 0, and no ld_done pulse.
